// File: rtl/ws2812_bit_encoder.sv
// WS2812 single-wire symbol encoder: each accepted bit becomes one BIT_CYC-long high/low symbol, and a latch request becomes an RST_CYC low period.
// Optional build macro WS2812_UNDERRUN_DETECT_EN adds a sticky underrun flag output.
module ws2812_bit_encoder #(
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40,
  parameter int BIT_CYC = 63,
  parameter int RST_CYC = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic bit_in,
  input  logic latch_req,
  output logic bit_ready,
  output logic dout,
  output logic busy,
`ifdef WS2812_UNDERRUN_DETECT_EN
  output logic underrun,
`endif
  output logic latch_done
);

  localparam int MAXC = (BIT_CYC > RST_CYC) ? BIT_CYC : RST_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  // Counters are loaded with (length - 1) and count down to 0, so they never wrap.
  localparam logic [CW-1:0] T0H_M1 = CW'(T0H_CYC - 1);
  localparam logic [CW-1:0] T1H_M1 = CW'(T1H_CYC - 1);
  localparam logic [CW-1:0] L0_M1  = CW'(BIT_CYC - T0H_CYC - 1);
  localparam logic [CW-1:0] L1_M1  = CW'(BIT_CYC - T1H_CYC - 1);
  localparam logic [CW-1:0] RST_M1 = CW'(RST_CYC - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          dout_nx;
  logic          cur_bit, cur_bit_nx;
  logic          last_low, acc_bit, acc_latch;

  assign last_low   = (state == LOW) && (cnt == '0);
  assign bit_ready  = !rst && ((state == IDLE) || last_low);
  assign acc_bit    = bit_ready && bit_valid;
  assign acc_latch  = bit_ready && !bit_valid && latch_req;
  assign busy       = !rst && (state != IDLE);
  assign latch_done = !rst && (state == LATCH) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dout    <= 1'b0;
      cur_bit <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      dout    <= dout_nx;
      cur_bit <= cur_bit_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    dout_nx    = dout;
    cur_bit_nx = cur_bit;
    if (acc_bit) begin
      state_nx   = HIGH;
      cnt_nx     = bit_in ? T1H_M1 : T0H_M1;
      dout_nx    = 1'b1;
      cur_bit_nx = bit_in;
    end else if (acc_latch) begin
      state_nx = LATCH;
      cnt_nx   = RST_M1;
      dout_nx  = 1'b0;
    end else begin
      case (state)
        HIGH: begin
          if (cnt == '0) begin
            state_nx = LOW;
            cnt_nx   = cur_bit ? L1_M1 : L0_M1;
            dout_nx  = 1'b0;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        LOW, LATCH: begin
          dout_nx = 1'b0;
          if (cnt == '0) state_nx = IDLE;
          else           cnt_nx   = cnt - 1'b1;
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          dout_nx  = 1'b0;
        end
      endcase
    end
  end

`ifdef WS2812_UNDERRUN_DETECT_EN
  // Sticky: the upstream feeder missed the only window for a back-to-back symbol.
  always_ff @(posedge clk) begin
    if (rst)                                          underrun <= 1'b0;
    else if (acc_latch)                               underrun <= 1'b0;
    else if (last_low && !bit_valid && !latch_req)    underrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Directed bench for ws2812_bit_encoder with short symbol timings (T0H=2, T1H=4, BIT=6, RST=10).
module tb_ws2812_bit_encoder;
  logic clk = 1'b0;
  logic rst, bit_valid, bit_in, latch_req;
  logic bit_ready, dout, busy, latch_done;
`ifdef WS2812_UNDERRUN_DETECT_EN
  logic underrun;
`endif

  int checks = 0;
  int failures = 0;

  ws2812_bit_encoder #(.T0H_CYC(2), .T1H_CYC(4), .BIT_CYC(6), .RST_CYC(10)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .latch_req(latch_req),
    .bit_ready(bit_ready), .dout(dout), .busy(busy),
`ifdef WS2812_UNDERRUN_DETECT_EN
    .underrun(underrun),
`endif
    .latch_done(latch_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  logic [17:0] stream_exp;
  logic [2:0]  stream_bits;
  int          ld_cnt, dout_hi_cnt;

  initial begin
    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; latch_req = 1'b0;
    step(); step();
    chk("rst_dout", dout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", bit_ready, 1'b0);
    chk("rst_latch_done", latch_done, 1'b0);
`ifdef WS2812_UNDERRUN_DETECT_EN
    chk("rst_underrun", underrun, 1'b0);
`endif
    rst = 1'b0; #1;
    chk("release_ready", bit_ready, 1'b1);
    step();

    // Single '1' symbol accepted at cycle 0.
    bit_valid = 1'b1; bit_in = 1'b1; #1;
    chk("single_ready_c0", bit_ready, 1'b1);
    step();
    bit_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("single_dout_c%0d", c), dout, (c <= 4));
      chk($sformatf("single_busy_c%0d", c), busy, 1'b1);
      chk($sformatf("single_ready_c%0d", c), bit_ready, (c == 6));
      step();
    end
    chk("single_idle_busy", busy, 1'b0);
    chk("single_idle_dout", dout, 1'b0);
    chk("single_idle_ready", bit_ready, 1'b1);
`ifdef WS2812_UNDERRUN_DETECT_EN
    chk("underrun_set", underrun, 1'b1);
`endif
    step();

    // Stream 1,0,1 back-to-back with bit_valid held high.
    stream_exp  = 18'b111100_110000_111100;
    stream_bits = 3'b101;
    for (int c = 0; c <= 18; c++) begin
      bit_valid = (c < 18);
      bit_in    = (c < 18) ? stream_bits[2 - c/6] : 1'b0;
      #1;
      chk($sformatf("stream_ready_c%0d", c), bit_ready, (c % 6 == 0));
      if (c >= 1) chk($sformatf("stream_dout_c%0d", c), dout, stream_exp[18 - c]);
      step();
    end
    chk("stream_end_busy", busy, 1'b0);
    step();

    // Bit and latch together: bit goes first, latch follows.
    bit_valid = 1'b1; latch_req = 1'b1; bit_in = 1'b0;
    step();
    bit_valid = 1'b0;
    ld_cnt = 0; dout_hi_cnt = 0;
    for (int c = 1; c <= 17; c++) begin
      if (c == 7) latch_req = 1'b0;
      #1;
      if (c <= 6) chk($sformatf("bl_dout_c%0d", c), dout, (c <= 2));
      if (c >= 7 && c <= 16) begin
        if (dout) dout_hi_cnt++;
        chk($sformatf("bl_busy_c%0d", c), busy, 1'b1);
      end
`ifdef WS2812_UNDERRUN_DETECT_EN
      if (c == 7) chk("underrun_cleared", underrun, 1'b0);
`endif
      if (latch_done) ld_cnt++;
      if (c == 16) chk("bl_latch_done_c16", latch_done, 1'b1);
      if (c == 17) chk("bl_idle_busy", busy, 1'b0);
      step();
    end
    checks++;
    assert (dout_hi_cnt == 0) else begin
      failures++;
      $error("FAIL bl_latch_dout_low observed=%0d expected=0", dout_hi_cnt);
    end
    checks++;
    assert (ld_cnt == 1) else begin
      failures++;
      $error("FAIL bl_latch_done_pulses observed=%0d expected=1", ld_cnt);
    end

    // Reset during third HIGH cycle of a '1' symbol.
    bit_valid = 1'b1; bit_in = 1'b1;
    step();
    bit_valid = 1'b0;
    step(); step();
    chk("abort_dout_c3", dout, 1'b1);
    rst = 1'b1;
    step();
    chk("abort_dout", dout, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", bit_ready, 1'b0);
    rst = 1'b0; #1;
    chk("abort_release_ready", bit_ready, 1'b1);
    step();
    chk("abort_idle_dout", dout, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
